card_lock_ctrl: RTL

CARD_LOCK_CTRL -- requirements
Module: card_lock_ctrl

---
 rtl/card_lock_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/card_lock_ctrl.sv
// Card-reader door lock: synchronised push buttons, programmable card table, timed unlock
// pulse and timed lockout after too many consecutive denials.
module card_lock_ctrl #(
   parameter int unsigned CARD_W          = 16,
   parameter int unsigned NUM_CARDS       = 4,
   parameter int unsigned UNLOCK_CYCLES   = 100000000,
   parameter int unsigned MAX_FAILS       = 3,
   parameter int unsigned LOCKOUT_CYCLES  = 500000000,
   localparam int unsigned IDX_W          = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1,
   localparam int unsigned FAIL_W         = $clog2(MAX_FAILS + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_key_clr,
   input  logic              i_key_set,
   input  logic [CARD_W-1:0] i_card_sw,
   input  logic              i_prog_we,
   input  logic [IDX_W-1:0]  i_prog_idx,
   output logic              o_card_read,
   output logic              o_door_open,
   output logic              o_denied,
   output logic              o_locked_out,
   output logic [FAIL_W-1:0] o_fail_cnt,
   output logic [IDX_W-1:0]  o_match_idx
);

   localparam int unsigned MAX_CYC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                      : LOCKOUT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0]  UNLOCK_LOAD  = CNT_W'(UNLOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0]  LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
   localparam logic [FAIL_W-1:0] FAIL_LAST    = FAIL_W'(MAX_FAILS - 1);
   localparam logic [FAIL_W-1:0] FAIL_MAX     = FAIL_W'(MAX_FAILS);

   typedef enum logic [1:0] {StIdle, StCheck, StUnlock, StLockout} state_e;

   state_e              r_state;
   logic                r_card_read;
   logic                r_door_open;
   logic                r_denied;
   logic                r_locked_out;
   logic [FAIL_W-1:0]   r_fail_cnt;
   logic [IDX_W-1:0]    r_match_idx;
   logic [CNT_W-1:0]    r_cnt;
   logic [NUM_CARDS-1:0] r_valid;
   logic [CARD_W-1:0]   r_card_reg;
   logic [CARD_W-1:0]   r_table [NUM_CARDS];

   logic r_set_s1, r_set_s2, r_set_h;
   logic r_clr_s1, r_clr_s2, r_clr_h;

   logic             w_set_press;
   logic             w_clr_press;
   logic             w_idx_ok;
   logic             w_wr_en;
   logic             w_hit;
   logic [IDX_W-1:0] w_hit_idx;

   // Two-flop synchronisers plus a history flop; buttons idle high
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_set_s1 <= 1'b1;
         r_set_s2 <= 1'b1;
         r_set_h  <= 1'b1;
         r_clr_s1 <= 1'b1;
         r_clr_s2 <= 1'b1;
         r_clr_h  <= 1'b1;
      end else begin
         r_set_s1 <= i_key_set;
         r_set_s2 <= r_set_s1;
         r_set_h  <= r_set_s2;
         r_clr_s1 <= i_key_clr;
         r_clr_s2 <= r_clr_s1;
         r_clr_h  <= r_clr_s2;
      end
   end

   assign w_set_press = r_set_h & ~r_set_s2;
   assign w_clr_press = r_clr_h & ~r_clr_s2;

   assign w_idx_ok = (32'(i_prog_idx) < NUM_CARDS);
   assign w_wr_en  = (r_state == StIdle) && i_prog_we && w_idx_ok;

   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         r_table[i_prog_idx] <= i_card_sw;
      end
   end

   // Scan from the top down so the lowest matching slot is the one that sticks
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = int'(NUM_CARDS) - 1; i >= 0; i--) begin
         if (r_valid[i] && (r_table[i] == r_card_reg)) begin
            w_hit     = 1'b1;
            w_hit_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_card_read  <= 1'b0;
         r_door_open  <= 1'b0;
         r_denied     <= 1'b0;
         r_locked_out <= 1'b0;
         r_fail_cnt   <= '0;
         r_match_idx  <= '0;
         r_cnt        <= '0;
         r_valid      <= '0;
         r_card_reg   <= '0;
      end else begin
         r_denied <= 1'b0;
         case (r_state)
            StIdle: begin
               // A table write swallows any coincident card read
               if (i_prog_we) begin
                  if (w_wr_en) begin
                     r_valid[i_prog_idx] <= 1'b1;
                  end
               end else if (w_set_press && !w_clr_press) begin
                  r_card_reg  <= i_card_sw;
                  r_card_read <= 1'b1;
                  r_state     <= StCheck;
               end
            end
            StCheck: begin
               if (w_clr_press) begin
                  r_card_read <= 1'b0;
                  r_state     <= StIdle;
               end else if (w_hit) begin
                  r_match_idx <= w_hit_idx;
                  r_fail_cnt  <= '0;
                  r_door_open <= 1'b1;
                  r_cnt       <= UNLOCK_LOAD;
                  r_state     <= StUnlock;
               end else if (r_fail_cnt >= FAIL_LAST) begin
                  r_fail_cnt   <= FAIL_MAX;
                  r_denied     <= 1'b1;
                  r_card_read  <= 1'b0;
                  r_locked_out <= 1'b1;
                  r_cnt        <= LOCKOUT_LOAD;
                  r_state      <= StLockout;
               end else begin
                  r_fail_cnt  <= r_fail_cnt + 1'b1;
                  r_denied    <= 1'b1;
                  r_card_read <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            StUnlock: begin
               if (w_clr_press || (r_cnt == '0)) begin
                  r_door_open <= 1'b0;
                  r_card_read <= 1'b0;
                  r_cnt       <= '0;
                  r_state     <= StIdle;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            StLockout: begin
               if (r_cnt == '0) begin
                  r_locked_out <= 1'b0;
                  r_fail_cnt   <= '0;
                  r_state      <= StIdle;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_card_read  = r_card_read;
   assign o_door_open  = r_door_open;
   assign o_denied     = r_denied;
   assign o_locked_out = r_locked_out;
   assign o_fail_cnt   = r_fail_cnt;
   assign o_match_idx  = r_match_idx;

endmodule
